execute_unit_m: RTL and testbench
=================================

Name: execute_unit_m

Overview:
- Parametrised successor to the pipeline execute stage.
- Decodes the RV32I/RV32M ALU, branch, jump, load/store and U-type classes. Applies forwarding muxes to operands and produces the EX/MEM pipeline register (result, store data, state, PC target).
- Adds an iterative multiply/divide engine (RV32M) with a valid/ready input handshake. Upstream stalls while a multi-cycle op is in flight.
- Sits between decode/forwarding and the memory/controller stage.

Parameters:
XLEN, 32, datapath/address width
REGW, 5, register-number width
STATEW, 4, pipeline state-code width
MDU_EN, 1, 1 = RV32M decoded; 0 = opcode 0110011 with func7=0000001 decodes as IDLE

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  kill current/in-flight op
hazard  in  1  force bubble into EX/MEM state
in_valid  in  1  decoded instruction present
in_ready  out  1  unit can accept (0 while MDU busy)
pc  in  XLEN  instruction PC
imm  in  XLEN  sign-extended immediate
opcode  in  7  opcode
func3  in  3  func3
func7  in  7  func7
rd  in  REGW  destination register
rs1_data  in  XLEN  register-file read 0
rs2_data  in  XLEN  register-file read 1
fwd_a  in  2  00 rs1_data, 01 wb_data, 1x mem_data
fwd_b  in  2  same encoding for rs2
wb_data  in  XLEN  writeback-stage forward value
mem_data  in  XLEN  memory-stage forward value
out_valid  out  1  EX/MEM register holds a valid op
out_state  out  STATEW  pipeline state code
out_result  out  XLEN  ALU/MDU result
out_store  out  XLEN  forwarded rs2 (store data / branch)
out_pc  out  XLEN  instruction PC
out_imm  out  XLEN  immediate
out_func3  out  3  func3
out_rd  out  REGW  destination
mem_read_en  out  1  out_state == MemReadRegWrite
mdu_busy  out  1  MDU iterating

Behaviour:
- Reset: all outputs 0, out_state = IDLE, MDU IDLE, in_ready = 1.
- Accept occurs when in_valid && in_ready at a clk edge.
- Non-MDU ops: 1-cycle latency; EX/MEM register updates on the accept edge.
- State by opcode:
  - R/I/auipc → RegWrite
  - load → MemReadRegWrite
  - store → MemWrite
  - branch → PCSelectWrite
  - jal/jalr → PCWrite
  - lui → LuiRegWrite
  - other → IDLE
- ALU operands:
  - jal/auipc: X = pc
  - otherwise: X = forwarded rs1
  - Y = imm for I/load/store/jalr/jal/auipc
  - Y = forwarded rs2 for R/branch
- I-type shift: srai when imm[10] = 1.
- Branch result: 1/0 compare (beq, bne, blt, bge, bltu, bgeu).
- out_store is always forwarded rs2.
- MDU state machine: IDLE → BUSY → DONE → IDLE.
  - Accepting an M-op drops in_ready on the next cycle.
  - BUSY runs XLEN cycles: radix-2 shift-add for mul; restoring division for div/rem.
  - DONE writes the EX/MEM register with state RegWrite, out_valid = 1, and raises in_ready.
  - Total latency: accept edge + XLEN + 1 edges.
- MDU bubbles: while BUSY, the EX/MEM register holds out_valid = 0, out_state = IDLE.
- MDU results:
  - mulh/mulhsu/mulhu: upper XLEN of the 2·XLEN product, with signedness per func3.
  - mul: lower XLEN.
- Special cases (resolve in 1 cycle, skip BUSY, go to DONE):
  - Divide by zero: quotient = all-ones; remainder = dividend.
  - Signed overflow (−2^(XLEN−1) ÷ −1): quotient = dividend; remainder = 0.
- hazard: the EX/MEM register latches state IDLE and out_valid = 0. Other fields latch normally.
- flush:
  - Next edge: out_valid = 0, state = IDLE.
  - Aborts the MDU from any state; MDU returns to IDLE and in_ready = 1 next cycle.
  - Same-cycle flush and accept: flush wins; nothing is accepted.
- reset mid-MDU: immediate return to IDLE; no result is emitted.
- Arithmetic wraps modulo 2^XLEN; shift amount uses Y[log2(XLEN)−1:0].

Decomposition:
- Shared defines header (package): state codes (IDLE, RegWrite, MemReadRegWrite, MemWrite, PCSelectWrite, PCWrite, LuiRegWrite), ALU op codes, opcode constants, width macros.
- Reuse the existing ALU.
- One new sub-module: mdu_iter (iterative mul/div engine with start/done/abort).

Test Plan:
- add x: rs1 = 5, rs2 = 7, fwd = 00 → next edge: out_result = 12, out_state = RegWrite, out_valid = 1.
- Forwarding: fwd_a = 10, mem_data = 100, sub with rs2 = 1 → out_result = 99. Then fwd_b = 01, wb_data = 3 on sw → out_store = 3, out_state = MemWrite.
- mulhu 0xFFFFFFFF × 0xFFFFFFFF:
  - in_ready = 0 for 33 cycles.
  - Result 0xFFFFFFFE appears at edge 34 after accept.
  - out_valid = 0 during busy.
- div 7/0 → quotient 0xFFFFFFFF; rem 7/0 → 7. div 0x80000000/0xFFFFFFFF → 0x80000000. Each completes in 2 edges.
- flush asserted 10 cycles into a divu → out_valid stays 0, mdu_busy = 0 next cycle, in_ready = 1. A following addi 1+2 yields 3.
- hazard on a load → out_state = IDLE, mem_read_en = 0. Reset asserted mid-mul → all outputs 0, in_ready = 1.

Source files
------------

// File: rtl/execute_unit_m_pkg.sv
// Shared definitions for the execute stage: pipeline state codes, ALU
// operation codes, RV32 opcode constants and the MDU sequencer states.
package execute_unit_m_pkg;

    // Pipeline state codes carried in the EX/MEM register.
    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_REGWRITE    = 4'd1,
        ST_MEMREAD     = 4'd2,
        ST_MEMWRITE    = 4'd3,
        ST_PCSELWRITE  = 4'd4,
        ST_PCWRITE     = 4'd5,
        ST_LUIREGWRITE = 4'd6
    } state_e;

    // Operation selected for the single-cycle ALU.
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_BR    = 4'd10,
        ALU_PASSB = 4'd11
    } alu_op_e;

    // Iterative multiply/divide sequencer states.
    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

endpackage

// File: rtl/execute_unit_m_mdu_iter.sv
// Iterative RV32M engine: radix-2 shift-add multiply and restoring division
// on operand magnitudes, sign fix-up applied when the result is presented.
// Divide-by-zero and signed overflow bypass the iteration entirely.
module mdu_iter
    import execute_unit_m_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [2:0]      func3_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            idle_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CNTW = $clog2(XLEN);

    mdu_state_e          state_q;
    logic [CNTW-1:0]     cnt_q;
    logic [2:0]          func3_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [2*XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]     opb_q;
    logic [XLEN:0]       rem_q;
    logic                neg_q;
    logic                rneg_q;
    logic                special_q;
    logic [XLEN-1:0]     spec_q;

    logic                is_div_s;
    logic                a_signed_s;
    logic                b_signed_s;
    logic                a_neg_s;
    logic                b_neg_s;
    logic [XLEN-1:0]     a_mag_s;
    logic [XLEN-1:0]     b_mag_s;
    logic                div0_s;
    logic                ovf_s;
    logic [XLEN-1:0]     spec_d;
    logic [XLEN:0]       shifted_s;
    logic [XLEN:0]       trial_s;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     quo_s;
    logic [XLEN-1:0]     rem_s;

    // Classify the incoming op: operand signedness, magnitudes and the two
    // division corner cases that resolve without iterating.
    always_comb begin
        is_div_s   = func3_i[2];
        if (is_div_s) begin
            a_signed_s = ~func3_i[0];
            b_signed_s = ~func3_i[0];
        end else begin
            a_signed_s = (func3_i[1:0] == 2'b01) || (func3_i[1:0] == 2'b10);
            b_signed_s = (func3_i[1:0] == 2'b01);
        end
        a_neg_s = a_signed_s & a_i[XLEN-1];
        b_neg_s = b_signed_s & b_i[XLEN-1];
        a_mag_s = a_neg_s ? -a_i : a_i;
        b_mag_s = b_neg_s ? -b_i : b_i;
        div0_s  = is_div_s && (b_i == {XLEN{1'b0}});
        ovf_s   = is_div_s && ~func3_i[0] &&
                  (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == {XLEN{1'b1}});
        if (div0_s) begin
            spec_d = func3_i[1] ? a_i : {XLEN{1'b1}};
        end else begin
            spec_d = func3_i[1] ? {XLEN{1'b0}} : a_i;
        end
    end

    // One restoring-division step: shift in the next dividend bit and try
    // to subtract the divisor; the extra top bit of trial is the borrow.
    always_comb begin
        shifted_s = {rem_q[XLEN-1:0], opb_q[XLEN-1]};
        trial_s   = shifted_s - {1'b0, mcand_q[XLEN-1:0]};
    end

    // Sequencer and datapath registers; abort drops back to IDLE from any state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MDU_IDLE;
            cnt_q     <= {CNTW{1'b0}};
            func3_q   <= 3'b000;
            acc_q     <= {(2*XLEN){1'b0}};
            mcand_q   <= {(2*XLEN){1'b0}};
            opb_q     <= {XLEN{1'b0}};
            rem_q     <= {(XLEN+1){1'b0}};
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            special_q <= 1'b0;
            spec_q    <= {XLEN{1'b0}};
        end else if (abort_i) begin
            state_q <= MDU_IDLE;
        end else begin
            case (state_q)
                MDU_IDLE: begin
                    if (start_i) begin
                        func3_q   <= func3_i;
                        cnt_q     <= {CNTW{1'b0}};
                        special_q <= div0_s | ovf_s;
                        spec_q    <= spec_d;
                        acc_q     <= {(2*XLEN){1'b0}};
                        mcand_q   <= {{XLEN{1'b0}}, (is_div_s ? b_mag_s : a_mag_s)};
                        opb_q     <= is_div_s ? a_mag_s : b_mag_s;
                        rem_q     <= {(XLEN+1){1'b0}};
                        neg_q     <= a_neg_s ^ b_neg_s;
                        rneg_q    <= a_neg_s;
                        state_q   <= (div0_s | ovf_s) ? MDU_DONE : MDU_BUSY;
                    end else begin
                        state_q <= MDU_IDLE;
                    end
                end
                MDU_BUSY: begin
                    if (func3_q[2]) begin
                        if (!trial_s[XLEN]) begin
                            rem_q <= trial_s;
                            opb_q <= {opb_q[XLEN-2:0], 1'b1};
                        end else begin
                            rem_q <= shifted_s;
                            opb_q <= {opb_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        if (opb_q[0]) begin
                            acc_q <= acc_q + mcand_q;
                        end else begin
                            acc_q <= acc_q;
                        end
                        mcand_q <= {mcand_q[2*XLEN-2:0], 1'b0};
                        opb_q   <= {1'b0, opb_q[XLEN-1:1]};
                    end
                    cnt_q <= cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
                    if (cnt_q == CNTW'(XLEN-1)) begin
                        state_q <= MDU_DONE;
                    end else begin
                        state_q <= MDU_BUSY;
                    end
                end
                MDU_DONE: begin
                    state_q <= MDU_IDLE;
                end
                default: begin
                    state_q <= MDU_IDLE;
                end
            endcase
        end
    end

    // Present the finished result with signs restored.
    always_comb begin
        prod_s = neg_q ? -acc_q : acc_q;
        quo_s  = neg_q ? -opb_q : opb_q;
        rem_s  = rneg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
        if (special_q) begin
            result_o = spec_q;
        end else if (!func3_q[2]) begin
            if (func3_q[1:0] == 2'b00) begin
                result_o = prod_s[XLEN-1:0];
            end else begin
                result_o = prod_s[2*XLEN-1:XLEN];
            end
        end else if (func3_q[1]) begin
            result_o = rem_s;
        end else begin
            result_o = quo_s;
        end
    end

    assign idle_o = (state_q == MDU_IDLE);
    assign busy_o = (state_q == MDU_BUSY);
    assign done_o = (state_q == MDU_DONE);

endmodule

// File: rtl/execute_unit_m.sv
// Execute stage: operand forwarding, RV32I decode and ALU, EX/MEM pipeline
// register, and an iterative RV32M engine that stalls upstream via in_ready.
module execute_unit_m
    import execute_unit_m_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REGW   = 5,
    parameter int STATEW = 4,
    parameter int MDU_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              hazard,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   imm,
    input  logic [6:0]        opcode,
    input  logic [2:0]        func3,
    input  logic [6:0]        func7,
    input  logic [REGW-1:0]   rd,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [1:0]        fwd_a,
    input  logic [1:0]        fwd_b,
    input  logic [XLEN-1:0]   wb_data,
    input  logic [XLEN-1:0]   mem_data,
    output logic              out_valid,
    output logic [STATEW-1:0] out_state,
    output logic [XLEN-1:0]   out_result,
    output logic [XLEN-1:0]   out_store,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_imm,
    output logic [2:0]        out_func3,
    output logic [REGW-1:0]   out_rd,
    output logic              mem_read_en,
    output logic              mdu_busy
);

    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0]   fa_s;
    logic [XLEN-1:0]   fb_s;
    logic [XLEN-1:0]   alu_x_s;
    logic [XLEN-1:0]   alu_y_s;
    logic [SHW-1:0]    shamt_s;
    logic [XLEN-1:0]   alu_res_s;
    logic              br_taken_s;
    alu_op_e           alu_op_s;
    state_e            dec_state_s;
    logic              is_mdu_s;
    logic              accept_s;
    logic              start_s;
    logic              ex_valid_d;
    logic [STATEW-1:0] ex_state_d;
    logic              ex_memrd_d;

    logic              mdu_idle_s;
    logic              mdu_busy_s;
    logic              mdu_done_s;
    logic [XLEN-1:0]   mdu_res_s;

    logic              valid_q;
    logic [STATEW-1:0] state_q;
    logic [XLEN-1:0]   result_q;
    logic [XLEN-1:0]   store_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   imm_q;
    logic [2:0]        func3_q;
    logic [REGW-1:0]   rd_q;
    logic              memrd_q;

    // Forwarding muxes for both source operands.
    always_comb begin
        case (fwd_a)
            2'b00:   fa_s = rs1_data;
            2'b01:   fa_s = wb_data;
            default: fa_s = mem_data;
        endcase
        case (fwd_b)
            2'b00:   fb_s = rs2_data;
            2'b01:   fb_s = wb_data;
            default: fb_s = mem_data;
        endcase
    end

    // Decode opcode class into pipeline state, ALU op and MDU request.
    always_comb begin
        dec_state_s = ST_IDLE;
        alu_op_s    = ALU_ADD;
        is_mdu_s    = 1'b0;
        case (opcode)
            OPC_OP, OPC_OPIMM: begin
                if ((opcode == OPC_OP) && (func7 == F7_MULDIV)) begin
                    if (MDU_EN != 0) begin
                        dec_state_s = ST_REGWRITE;
                        is_mdu_s    = 1'b1;
                    end else begin
                        dec_state_s = ST_IDLE;
                    end
                end else begin
                    dec_state_s = ST_REGWRITE;
                end
                case (func3)
                    3'b000:  alu_op_s = ((opcode == OPC_OP) && func7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op_s = ALU_SLL;
                    3'b010:  alu_op_s = ALU_SLT;
                    3'b011:  alu_op_s = ALU_SLTU;
                    3'b100:  alu_op_s = ALU_XOR;
                    3'b101: begin
                        if (opcode == OPC_OP) begin
                            alu_op_s = func7[5] ? ALU_SRA : ALU_SRL;
                        end else begin
                            alu_op_s = imm[10] ? ALU_SRA : ALU_SRL;
                        end
                    end
                    3'b110:  alu_op_s = ALU_OR;
                    3'b111:  alu_op_s = ALU_AND;
                    default: alu_op_s = ALU_ADD;
                endcase
            end
            OPC_AUIPC:  dec_state_s = ST_REGWRITE;
            OPC_LOAD:   dec_state_s = ST_MEMREAD;
            OPC_STORE:  dec_state_s = ST_MEMWRITE;
            OPC_BRANCH: begin
                dec_state_s = ST_PCSELWRITE;
                alu_op_s    = ALU_BR;
            end
            OPC_JAL, OPC_JALR: dec_state_s = ST_PCWRITE;
            OPC_LUI: begin
                dec_state_s = ST_LUIREGWRITE;
                alu_op_s    = ALU_PASSB;
            end
            default: dec_state_s = ST_IDLE;
        endcase
    end

    // ALU operand selection: PC-relative ops use pc, register-register ops use rs2.
    always_comb begin
        if ((opcode == OPC_JAL) || (opcode == OPC_AUIPC)) begin
            alu_x_s = pc;
        end else begin
            alu_x_s = fa_s;
        end
        if ((opcode == OPC_OP) || (opcode == OPC_BRANCH)) begin
            alu_y_s = fb_s;
        end else begin
            alu_y_s = imm;
        end
    end

    assign shamt_s = alu_y_s[SHW-1:0];

    // Branch comparison on forwarded operands.
    always_comb begin
        case (func3)
            3'b000:  br_taken_s = (alu_x_s == alu_y_s);
            3'b001:  br_taken_s = (alu_x_s != alu_y_s);
            3'b100:  br_taken_s = ($signed(alu_x_s) <  $signed(alu_y_s));
            3'b101:  br_taken_s = ($signed(alu_x_s) >= $signed(alu_y_s));
            3'b110:  br_taken_s = (alu_x_s <  alu_y_s);
            3'b111:  br_taken_s = (alu_x_s >= alu_y_s);
            default: br_taken_s = 1'b0;
        endcase
    end

    // Single-cycle ALU.
    always_comb begin
        case (alu_op_s)
            ALU_ADD:   alu_res_s = alu_x_s + alu_y_s;
            ALU_SUB:   alu_res_s = alu_x_s - alu_y_s;
            ALU_SLL:   alu_res_s = alu_x_s << shamt_s;
            ALU_SLT:   alu_res_s = {{(XLEN-1){1'b0}}, ($signed(alu_x_s) < $signed(alu_y_s))};
            ALU_SLTU:  alu_res_s = {{(XLEN-1){1'b0}}, (alu_x_s < alu_y_s)};
            ALU_XOR:   alu_res_s = alu_x_s ^ alu_y_s;
            ALU_SRL:   alu_res_s = alu_x_s >> shamt_s;
            ALU_SRA:   alu_res_s = $signed(alu_x_s) >>> shamt_s;
            ALU_OR:    alu_res_s = alu_x_s | alu_y_s;
            ALU_AND:   alu_res_s = alu_x_s & alu_y_s;
            ALU_BR:    alu_res_s = {{(XLEN-1){1'b0}}, br_taken_s};
            ALU_PASSB: alu_res_s = alu_y_s;
            default:   alu_res_s = {XLEN{1'b0}};
        endcase
    end

    // Handshake: flush wins over a same-cycle accept; hazard suppresses MDU start.
    always_comb begin
        accept_s   = in_valid && mdu_idle_s && !flush;
        start_s    = accept_s && is_mdu_s && !hazard;
        ex_valid_d = !hazard && !is_mdu_s && (dec_state_s != ST_IDLE);
        if (ex_valid_d) begin
            ex_state_d = STATEW'(dec_state_s);
        end else begin
            ex_state_d = STATEW'(ST_IDLE);
        end
        ex_memrd_d = ex_valid_d && (dec_state_s == ST_MEMREAD);
    end

    mdu_iter #(
        .XLEN (XLEN)
    ) u_mdu (
        .clk      (clk),
        .reset    (reset),
        .start_i  (start_s),
        .abort_i  (flush),
        .func3_i  (func3),
        .a_i      (fa_s),
        .b_i      (fb_s),
        .idle_o   (mdu_idle_s),
        .busy_o   (mdu_busy_s),
        .done_o   (mdu_done_s),
        .result_o (mdu_res_s)
    );

    // EX/MEM pipeline register: flush > MDU completion > accepted op > bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            state_q  <= STATEW'(ST_IDLE);
            result_q <= {XLEN{1'b0}};
            store_q  <= {XLEN{1'b0}};
            pc_q     <= {XLEN{1'b0}};
            imm_q    <= {XLEN{1'b0}};
            func3_q  <= 3'b000;
            rd_q     <= {REGW{1'b0}};
            memrd_q  <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
            state_q <= STATEW'(ST_IDLE);
            memrd_q <= 1'b0;
        end else if (mdu_done_s) begin
            result_q <= mdu_res_s;
            valid_q  <= !hazard;
            state_q  <= hazard ? STATEW'(ST_IDLE) : STATEW'(ST_REGWRITE);
            memrd_q  <= 1'b0;
        end else if (accept_s) begin
            valid_q  <= ex_valid_d;
            state_q  <= ex_state_d;
            memrd_q  <= ex_memrd_d;
            result_q <= alu_res_s;
            store_q  <= fb_s;
            pc_q     <= pc;
            imm_q    <= imm;
            func3_q  <= func3;
            rd_q     <= rd;
        end else begin
            valid_q <= 1'b0;
            state_q <= STATEW'(ST_IDLE);
            memrd_q <= 1'b0;
        end
    end

    assign in_ready    = mdu_idle_s;
    assign mdu_busy    = mdu_busy_s;
    assign out_valid   = valid_q;
    assign out_state   = state_q;
    assign out_result  = result_q;
    assign out_store   = store_q;
    assign out_pc      = pc_q;
    assign out_imm     = imm_q;
    assign out_func3   = func3_q;
    assign out_rd      = rd_q;
    assign mem_read_en = memrd_q;

endmodule

// File: tb/tb_execute_unit_m.sv
// Directed self-checking bench for execute_unit_m.
module tb_execute_unit_m;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_LU = 7'b0110111;
    localparam logic [6:0] OP_JL = 7'b1101111;
    localparam logic [6:0] F7_M  = 7'b0000001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        hazard = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] pc = 32'h0;
    logic [31:0] imm = 32'h0;
    logic [6:0]  opcode = 7'h0;
    logic [2:0]  func3 = 3'h0;
    logic [6:0]  func7 = 7'h0;
    logic [4:0]  rd = 5'd1;
    logic [31:0] rs1_data = 32'h0;
    logic [31:0] rs2_data = 32'h0;
    logic [1:0]  fwd_a = 2'b00;
    logic [1:0]  fwd_b = 2'b00;
    logic [31:0] wb_data = 32'h0;
    logic [31:0] mem_data = 32'h0;
    logic        out_valid;
    logic [3:0]  out_state;
    logic [31:0] out_result;
    logic [31:0] out_store;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [2:0]  out_func3;
    logic [4:0]  out_rd;
    logic        mem_read_en;
    logic        mdu_busy;

    int checks_cnt = 0;
    int errors_cnt = 0;

    execute_unit_m dut (
        .clk(clk), .reset(reset), .flush(flush), .hazard(hazard),
        .in_valid(in_valid), .in_ready(in_ready), .pc(pc), .imm(imm),
        .opcode(opcode), .func3(func3), .func7(func7), .rd(rd),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .wb_data(wb_data), .mem_data(mem_data), .out_valid(out_valid),
        .out_state(out_state), .out_result(out_result), .out_store(out_store),
        .out_pc(out_pc), .out_imm(out_imm), .out_func3(out_func3), .out_rd(out_rd),
        .mem_read_en(mem_read_en), .mdu_busy(mdu_busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
        opcode = op; func3 = f3; func7 = f7;
        rs1_data = a; rs2_data = b; imm = im;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Issue an M-op and wait for its result; lat counts edges from accept (accept = 1).
    task automatic run_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output int lat, output int low, output int bad);
        issue(OP_R, f3, F7_M, a, b, 32'h0);
        lat = 1; low = 0; bad = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) low++;
            if (in_ready && lat > 1) bad++;
            tick();
            lat++;
        end
        res = out_result;
    endtask

    initial begin
        logic [31:0] res;
        int lat, low, bad, vcnt;

        // reset state
        tick(); tick();
        check_val("rst_valid",  32'(out_valid), 32'd0);
        check_val("rst_state",  32'(out_state), 32'd0);
        check_val("rst_result", out_result, 32'd0);
        check_val("rst_pc",     out_pc, 32'd0);
        check_val("rst_ready",  32'(in_ready), 32'd1);
        check_val("rst_busy",   32'(mdu_busy), 32'd0);
        reset = 1'b0;
        tick();

        // add 5+7
        pc = 32'h40;
        issue(OP_R, 3'b000, 7'h00, 32'd5, 32'd7, 32'h0);
        check_val("add_res",   out_result, 32'd12);
        check_val("add_state", 32'(out_state), 32'd1);
        check_val("add_valid", 32'(out_valid), 32'd1);
        check_val("add_pc",    out_pc, 32'h40);

        // sub with mem forward on rs1
        fwd_a = 2'b10; mem_data = 32'd100;
        issue(OP_R, 3'b000, 7'b0100000, 32'd0, 32'd1, 32'h0);
        check_val("sub_fwd", out_result, 32'd99);
        fwd_a = 2'b00;

        // sw with wb forward on rs2
        fwd_b = 2'b01; wb_data = 32'd3;
        issue(OP_ST, 3'b010, 7'h00, 32'h1000, 32'hDEAD, 32'd4);
        check_val("sw_store", out_store, 32'd3);
        check_val("sw_state", 32'(out_state), 32'd3);
        check_val("sw_addr",  out_result, 32'h1004);
        fwd_b = 2'b00;

        // load under hazard, then a clean load
        hazard = 1'b1;
        issue(OP_LD, 3'b010, 7'h00, 32'h200, 32'h0, 32'd8);
        check_val("hz_state", 32'(out_state), 32'd0);
        check_val("hz_memrd", 32'(mem_read_en), 32'd0);
        check_val("hz_valid", 32'(out_valid), 32'd0);
        check_val("hz_res",   out_result, 32'h208);
        hazard = 1'b0;
        issue(OP_LD, 3'b010, 7'h00, 32'h200, 32'h0, 32'd8);
        check_val("ld_state", 32'(out_state), 32'd2);
        check_val("ld_memrd", 32'(mem_read_en), 32'd1);

        // shifts: srai vs srli by imm[10]
        issue(OP_I, 3'b101, 7'h00, 32'h80000000, 32'h0, 32'h404);
        check_val("srai", out_result, 32'hF8000000);
        issue(OP_I, 3'b101, 7'h00, 32'h80000000, 32'h0, 32'h004);
        check_val("srli", out_result, 32'h08000000);

        // branches
        issue(OP_BR, 3'b100, 7'h00, 32'hFFFFFFFF, 32'd1, 32'h0);
        check_val("blt_res",   out_result, 32'd1);
        check_val("blt_state", 32'(out_state), 32'd4);
        issue(OP_BR, 3'b110, 7'h00, 32'hFFFFFFFF, 32'd1, 32'h0);
        check_val("bltu_res",  out_result, 32'd0);

        // lui and jal
        issue(OP_LU, 3'b000, 7'h00, 32'h0, 32'h0, 32'h12345000);
        check_val("lui_res",   out_result, 32'h12345000);
        check_val("lui_state", 32'(out_state), 32'd6);
        pc = 32'h100;
        issue(OP_JL, 3'b000, 7'h00, 32'h0, 32'h0, 32'd8);
        check_val("jal_res",   out_result, 32'h108);
        check_val("jal_state", 32'(out_state), 32'd5);

        // mulhu full-width
        run_mdu(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat, low, bad);
        check_val("mulhu_res",   res, 32'hFFFFFFFE);
        check_val("mulhu_lat",   32'(lat), 32'd34);
        check_val("mulhu_low",   32'(low), 32'd33);
        check_val("mulhu_bub",   32'(bad), 32'd0);
        check_val("mulhu_state", 32'(out_state), 32'd1);
        check_val("mulhu_ready", 32'(in_ready), 32'd1);

        run_mdu(3'b000, 32'hFFFFFFFD, 32'd5, res, lat, low, bad);
        check_val("mul_res", res, 32'hFFFFFFF1);
        run_mdu(3'b001, 32'hFFFFFFFD, 32'd5, res, lat, low, bad);
        check_val("mulh_res", res, 32'hFFFFFFFF);
        run_mdu(3'b100, 32'hFFFFFFF9, 32'd2, res, lat, low, bad);
        check_val("div_neg", res, 32'hFFFFFFFD);
        run_mdu(3'b110, 32'hFFFFFFF9, 32'd2, res, lat, low, bad);
        check_val("rem_neg", res, 32'hFFFFFFFF);
        run_mdu(3'b101, 32'd100, 32'd7, res, lat, low, bad);
        check_val("divu_res", res, 32'd14);

        // special cases resolve in 2 edges
        run_mdu(3'b100, 32'd7, 32'd0, res, lat, low, bad);
        check_val("div0_res", res, 32'hFFFFFFFF);
        check_val("div0_lat", 32'(lat), 32'd2);
        run_mdu(3'b110, 32'd7, 32'd0, res, lat, low, bad);
        check_val("rem0_res", res, 32'd7);
        run_mdu(3'b100, 32'h80000000, 32'hFFFFFFFF, res, lat, low, bad);
        check_val("ovf_res", res, 32'h80000000);
        check_val("ovf_lat", 32'(lat), 32'd2);
        run_mdu(3'b110, 32'h80000000, 32'hFFFFFFFF, res, lat, low, bad);
        check_val("ovf_rem", res, 32'd0);

        // flush 10 cycles into divu, then addi
        issue(OP_R, 3'b101, F7_M, 32'd100, 32'd7, 32'h0);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_val("fl_valid", 32'(out_valid), 32'd0);
        check_val("fl_busy",  32'(mdu_busy), 32'd0);
        check_val("fl_ready", 32'(in_ready), 32'd1);
        issue(OP_I, 3'b000, 7'h00, 32'd1, 32'h0, 32'd2);
        check_val("fl_addi", out_result, 32'd3);
        check_val("fl_addi_v", 32'(out_valid), 32'd1);
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) vcnt++;
        end
        check_val("fl_noresult", 32'(vcnt), 32'd0);

        // flush and accept in the same cycle: nothing taken
        flush = 1'b1;
        issue(OP_R, 3'b000, F7_M, 32'd3, 32'd3, 32'h0);
        flush = 1'b0;
        check_val("flacc_valid", 32'(out_valid), 32'd0);
        check_val("flacc_ready", 32'(in_ready), 32'd1);
        tick();
        check_val("flacc_busy", 32'(mdu_busy), 32'd0);

        // reset mid-multiply
        issue(OP_R, 3'b000, F7_M, 32'd9, 32'd9, 32'h0);
        repeat (5) tick();
        check_val("rm_busy_pre", 32'(mdu_busy), 32'd1);
        reset = 1'b1;
        tick();
        check_val("rm_valid",  32'(out_valid), 32'd0);
        check_val("rm_result", out_result, 32'd0);
        check_val("rm_store",  out_store, 32'd0);
        check_val("rm_ready",  32'(in_ready), 32'd1);
        check_val("rm_busy",   32'(mdu_busy), 32'd0);
        reset = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) vcnt++;
        end
        check_val("rm_noresult", 32'(vcnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
